// File: rtl/proj1_alu_seq.sv
// Sequencer and register file wrapped around proj1_alu: issues one instruction at a
// time, waits out the ALU latency, then writes back the result and C/N/Z status.
`timescale 1ns/1ps
module proj1_alu_seq #(
  parameter int NREG    = 16,
  parameter int AW      = 4,
  parameter int ALU_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_opcode,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rr,
  output logic [7:0]    alu_data_rd,
  output logic [7:0]    alu_data_rr,
  output logic [7:0]    alu_opcode,
  output logic          alu_ci,
  input  logic [15:0]   alu_data_o,
  input  logic          alu_co,
  input  logic          alu_no,
  input  logic          alu_zo,
  output logic          done,
  output logic          illegal,
  output logic          flag_c,
  output logic          flag_n,
  output logic          flag_z,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WB} state_t;
  typedef enum logic [1:0] {C_STD, C_MUL, C_ILL} cls_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cls_t          cls_q, in_cls;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rd_hi;
  logic [7:0]    regs_q [NREG];
  logic [7:0]    alu_rd_q, alu_rr_q, alu_op_q;
  logic          alu_ci_q;
  logic          fc_q, fn_q, fz_q;
  logic          done_q, ill_q;
  logic          accept, ld_we, wb;

  // Opcode class is decoded at accept so writeback only needs the latched class.
  always_comb begin
    in_cls = C_ILL;
    casez (in_opcode)
      8'b0000_????, 8'b1000_????, 8'b1001_????,
      8'b1010_????, 8'b1011_??00, 8'b11??_????: in_cls = C_STD;
      8'b0100_????:                             in_cls = C_MUL;
      default:                                  in_cls = C_ILL;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    ld_we   = 1'b0;
    wb      = 1'b0;
    case (state_q)
      S_IDLE: begin
        ld_we  = ld_en;
        accept = in_valid && !ld_en;
        if (accept) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ALU_LAT - 1)) state_d = S_WB;
      end
      S_WB: begin
        wb      = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready = (state_q == S_IDLE) && !ld_en;
  assign rd_hi    = rd_q + AW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cls_q    <= C_STD;
      rd_q     <= '0;
      alu_rd_q <= '0;
      alu_rr_q <= '0;
      alu_op_q <= '0;
      alu_ci_q <= 1'b0;
      fc_q     <= 1'b0;
      fn_q     <= 1'b0;
      fz_q     <= 1'b0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= wb;
      ill_q   <= wb && (cls_q == C_ILL);
      if (accept) begin
        alu_rd_q <= regs_q[in_rd];
        alu_rr_q <= regs_q[in_rr];
        alu_op_q <= in_opcode;
        alu_ci_q <= fc_q;
        rd_q     <= in_rd;
        cls_q    <= in_cls;
      end
      if (ld_we) regs_q[ld_addr] <= ld_data;
      // Multiply keeps N and writes the high byte to the next register (wrapping).
      if (wb && (cls_q != C_ILL)) begin
        regs_q[rd_q] <= alu_data_o[7:0];
        fc_q         <= alu_co;
        fz_q         <= alu_zo;
        if (cls_q == C_STD) fn_q <= alu_no;
        else                regs_q[rd_hi] <= alu_data_o[15:8];
      end
    end
  end

  assign alu_data_rd = alu_rd_q;
  assign alu_data_rr = alu_rr_q;
  assign alu_opcode  = alu_op_q;
  assign alu_ci      = alu_ci_q;
  assign done        = done_q;
  assign illegal     = ill_q;
  assign flag_c      = fc_q;
  assign flag_n      = fn_q;
  assign flag_z      = fz_q;
  assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_proj1_alu_seq.sv
// Bench for proj1_alu_seq: a two-stage behavioural ALU feeds the DUT, and a
// register-file/flag reference model predicts every writeback.
`timescale 1ns/1ps
module tb_proj1_alu_seq;
  localparam int NREG = 16;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ld_en, in_valid, in_ready;
  logic [AW-1:0] ld_addr, in_rd, in_rr, dbg_addr;
  logic [7:0]    ld_data, in_opcode, dbg_data;
  logic [7:0]    alu_data_rd, alu_data_rr, alu_opcode;
  logic          alu_ci, alu_co, alu_no, alu_zo;
  logic [15:0]   alu_data_o;
  logic          done, illegal, flag_c, flag_n, flag_z;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_r  [NREG];
  logic [7:0] snap_r [NREG];
  logic       ref_c, ref_n, ref_z;
  logic [18:0] alu_p1, alu_p2;

  always #5 clk = ~clk;

  proj1_alu_seq #(.NREG(NREG), .AW(AW), .ALU_LAT(2)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rr(in_rr), .alu_data_rd(alu_data_rd),
    .alu_data_rr(alu_data_rr), .alu_opcode(alu_opcode), .alu_ci(alu_ci),
    .alu_data_o(alu_data_o), .alu_co(alu_co), .alu_no(alu_no), .alu_zo(alu_zo),
    .done(done), .illegal(illegal), .flag_c(flag_c), .flag_n(flag_n),
    .flag_z(flag_z), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Result packing: {co, no, zo, data[15:0]}
  function automatic logic [18:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] op, input logic ci);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  t;
    logic [18:0] r;
    r = {3'b111, a, b};
    if (op[7:6] == 2'b11) begin
      case (op[5:4])
        2'd0:    s = {1'b0, a} + {1'b0, b};
        2'd1:    s = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        2'd2:    s = {1'b0, a} - {1'b0, b};
        default: s = {1'b0, a} - {1'b0, b} - {8'd0, ci};
      endcase
      r = {s[8], s[7], s[7:0] == 8'd0, 8'h00, s[7:0]};
    end else if (op[7:4] == 4'b0100) begin
      p = {8'h00, a} * {8'h00, b};
      r = {p[15], p[15], p == 16'd0, p};
    end else if (op[7:4] == 4'b0000) begin
      s = {a, 1'b0};
      r = {s[8], s[7], s[7:0] == 8'd0, 8'h00, s[7:0]};
    end else if (op[7:4] == 4'b1000 || op[7:4] == 4'b1001 || op[7:4] == 4'b1010) begin
      t = (op[5:4] == 2'b00) ? (a & b) : (op[5:4] == 2'b01) ? (a | b) : (a ^ b);
      r = {1'b0, t[7], t == 8'd0, 8'h00, t};
    end else if (op[7:4] == 4'b1011) begin
      s = 9'd0 - {1'b0, a};
      r = {s[8], s[7], s[7:0] == 8'd0, 8'h00, s[7:0]};
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_p1 <= '0;
      alu_p2 <= '0;
    end else begin
      alu_p1 <= alu_f(alu_data_rd, alu_data_rr, alu_opcode, alu_ci);
      alu_p2 <= alu_p1;
    end
  end
  assign alu_data_o = alu_p2[15:0];
  assign alu_zo     = alu_p2[16];
  assign alu_no     = alu_p2[17];
  assign alu_co     = alu_p2[18];

  // 0 = ordinary writeback, 1 = multiply, 2 = undefined
  function automatic int op_class(input logic [7:0] op);
    case (op[7:4])
      4'h0, 4'h8, 4'h9, 4'hA: return 0;
      4'hB:                   return (op[1:0] == 2'b00) ? 0 : 2;
      4'h4:                   return 1;
      default:                return (op[7:6] == 2'b11) ? 0 : 2;
    endcase
  endfunction

  task automatic ref_exec(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rr);
    logic [18:0] r;
    int cl;
    r  = alu_f(ref_r[rd], ref_r[rr], op, ref_c);
    cl = op_class(op);
    if (cl == 0) begin
      ref_r[rd] = r[7:0];
      ref_c = r[18]; ref_n = r[17]; ref_z = r[16];
    end else if (cl == 1) begin
      ref_r[rd] = r[7:0];
      ref_r[(int'(rd) + 1) % NREG] = r[15:8];
      ref_c = r[18]; ref_z = r[16];
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < NREG; i++) ref_r[i] = 8'h00;
    ref_c = 1'b0; ref_n = 1'b0; ref_z = 1'b0;
  endtask

  task automatic snap();
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = AW'(i);
      #1 snap_r[i] = dbg_data;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [3:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    ref_r[a] = d;
  endtask

  // Issues one instruction from idle and watches 8 cycles for done/illegal.
  task automatic run_instr(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rr,
                           output int lat, output int nd, output logic ill,
                           output logic [7:0] s_rd, output logic [7:0] s_rr,
                           output logic [7:0] s_op, output logic s_ci, output logic rdy);
    in_opcode = op; in_rd = rd; in_rr = rr; in_valid = 1'b1;
    #1 rdy = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    s_rd = alu_data_rd; s_rr = alu_data_rr; s_op = alu_opcode; s_ci = alu_ci;
    lat = -1; nd = 0; ill = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (lat < 0) begin lat = k; ill = illegal; end
      end
    end
  endtask

  task automatic test_reset();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", in_ready); end
    n_checks++; if ({done, illegal} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b exp 00", {done, illegal}); end
    n_checks++; if ({flag_c, flag_n, flag_z} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b exp 000", {flag_c, flag_n, flag_z}); end
    n_checks++; if ({alu_data_rd, alu_data_rr, alu_opcode, alu_ci} !== 25'd0) begin n_fail++; $display("FAIL reset_alu_out: got %h exp 0", {alu_data_rd, alu_data_rr, alu_opcode, alu_ci}); end
    snap();
    for (int i = 0; i < NREG; i++) begin
      n_checks++; if (snap_r[i] !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d: got %h exp 00", i, snap_r[i]); end
    end
  endtask

  task automatic test_add();
    int lat, nd; logic ill, sci, rdy; logic [7:0] srd, srr, sop;
    do_load(4'd1, 8'h05); do_load(4'd2, 8'h03);
    run_instr(8'hC0, 4'd1, 4'd2, lat, nd, ill, srd, srr, sop, sci, rdy);
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %b exp 1", rdy); end
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL add_latency: got %0d exp 3", lat); end
    n_checks++; if (nd != 1) begin n_fail++; $display("FAIL add_done_count: got %0d exp 1", nd); end
    n_checks++; if (ill !== 1'b0) begin n_fail++; $display("FAIL add_illegal: got %b exp 0", ill); end
    n_checks++; if ({srd, srr, sop, sci} !== {8'h05, 8'h03, 8'hC0, 1'b0}) begin n_fail++; $display("FAIL add_alu_in: got %h exp %h", {srd, srr, sop, sci}, {8'h05, 8'h03, 8'hC0, 1'b0}); end
    ref_exec(8'hC0, 4'd1, 4'd2);
    snap();
    n_checks++; if ({snap_r[1], snap_r[2]} !== 16'h0803) begin n_fail++; $display("FAIL add_result: got %h exp 0803", {snap_r[1], snap_r[2]}); end
    n_checks++; if ({flag_c, flag_n, flag_z} !== {ref_c, ref_n, ref_z}) begin n_fail++; $display("FAIL add_flags: got %b exp %b", {flag_c, flag_n, flag_z}, {ref_c, ref_n, ref_z}); end
  endtask

  task automatic test_mult();
    int lat, nd; logic ill, sci, rdy; logic [7:0] srd, srr, sop;
    do_load(4'd7, 8'h00); do_load(4'd8, 8'h01);
    run_instr(8'hE0, 4'd7, 4'd8, lat, nd, ill, srd, srr, sop, sci, rdy);
    ref_exec(8'hE0, 4'd7, 4'd8);
    n_checks++; if (flag_n !== 1'b1) begin n_fail++; $display("FAIL sub_neg_flag: got %b exp 1", flag_n); end
    do_load(4'd4, 8'h20); do_load(4'd6, 8'h10);
    run_instr(8'h40, 4'd4, 4'd6, lat, nd, ill, srd, srr, sop, sci, rdy);
    n_checks++; if (lat != 3 || nd != 1) begin n_fail++; $display("FAIL mul_done: got lat %0d count %0d exp 3/1", lat, nd); end
    ref_exec(8'h40, 4'd4, 4'd6);
    snap();
    n_checks++; if ({snap_r[4], snap_r[5]} !== {ref_r[4], ref_r[5]}) begin n_fail++; $display("FAIL mul_result: got %h exp %h", {snap_r[4], snap_r[5]}, {ref_r[4], ref_r[5]}); end
    n_checks++; if ({flag_c, flag_n, flag_z} !== {ref_c, ref_n, ref_z}) begin n_fail++; $display("FAIL mul_flags: got %b exp %b", {flag_c, flag_n, flag_z}, {ref_c, ref_n, ref_z}); end
    do_load(4'd15, 8'h11); do_load(4'd14, 8'h22);
    run_instr(8'h4F, 4'd15, 4'd14, lat, nd, ill, srd, srr, sop, sci, rdy);
    ref_exec(8'h4F, 4'd15, 4'd14);
    snap();
    n_checks++; if ({snap_r[15], snap_r[0]} !== {ref_r[15], ref_r[0]}) begin n_fail++; $display("FAIL mul_wrap: got %h exp %h", {snap_r[15], snap_r[0]}, {ref_r[15], ref_r[0]}); end
  endtask

  task automatic test_carry();
    int lat, nd; logic ill, sci, rdy; logic [7:0] srd, srr, sop;
    do_load(4'd1, 8'hFF); do_load(4'd2, 8'h01);
    run_instr(8'hC0, 4'd1, 4'd2, lat, nd, ill, srd, srr, sop, sci, rdy);
    ref_exec(8'hC0, 4'd1, 4'd2);
    n_checks++; if ({flag_c, flag_z} !== {ref_c, ref_z}) begin n_fail++; $display("FAIL carry_out: got %b exp %b", {flag_c, flag_z}, {ref_c, ref_z}); end
    run_instr(8'hD0, 4'd1, 4'd1, lat, nd, ill, srd, srr, sop, sci, rdy);
    n_checks++; if (sci !== 1'b1) begin n_fail++; $display("FAIL addc_ci: got %b exp 1", sci); end
    n_checks++; if (srd !== srr) begin n_fail++; $display("FAIL same_reg_operands: got %h/%h exp equal", srd, srr); end
    ref_exec(8'hD0, 4'd1, 4'd1);
    snap();
    n_checks++; if (snap_r[1] !== ref_r[1]) begin n_fail++; $display("FAIL addc_result: got %h exp %h", snap_r[1], ref_r[1]); end
  endtask

  task automatic test_illegal();
    int lat, nd; logic ill, sci, rdy; logic [7:0] srd, srr, sop;
    logic [7:0] ops [3] = '{8'h10, 8'hB1, 8'h7F};
    do_load(4'd3, 8'h5A);
    foreach (ops[j]) begin
      run_instr(ops[j], 4'd3, 4'd2, lat, nd, ill, srd, srr, sop, sci, rdy);
      n_checks++; if (ill !== 1'b1 || lat != 3 || nd != 1) begin n_fail++; $display("FAIL illegal_pulse_%h: got ill %b lat %0d count %0d exp 1/3/1", ops[j], ill, lat, nd); end
      ref_exec(ops[j], 4'd3, 4'd2);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready: got %b exp 1", in_ready); end
      n_checks++; if ({flag_c, flag_n, flag_z} !== {ref_c, ref_n, ref_z}) begin n_fail++; $display("FAIL illegal_flags: got %b exp %b", {flag_c, flag_n, flag_z}, {ref_c, ref_n, ref_z}); end
    end
    snap();
    for (int i = 0; i < NREG; i++) begin
      n_checks++; if (snap_r[i] !== ref_r[i]) begin n_fail++; $display("FAIL illegal_reg%0d: got %h exp %h", i, snap_r[i], ref_r[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] std_ops [6] = '{8'hC0, 8'hD0, 8'hE0, 8'h80, 8'h90, 8'h00};
    int acc_c [$];
    logic [7:0] acc_op [$];
    logic [3:0] acc_rd [$], acc_rr [$];
    int ndone = 0;
    logic rdy;
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_opcode = std_ops[$urandom_range(0, 5)];
      in_rd = 4'(c + 1);
      in_rr = 4'($urandom_range(0, 15));
      ld_en = (c == 2); ld_addr = 4'd12; ld_data = 8'hA5;
      #1 rdy = in_ready;
      n_checks++; if (rdy !== ((c % 4) == 0)) begin n_fail++; $display("FAIL b2b_ready_c%0d: got %b exp %b", c, rdy, (c % 4) == 0); end
      if (rdy && in_valid) begin
        acc_c.push_back(c); acc_op.push_back(in_opcode); acc_rd.push_back(in_rd); acc_rr.push_back(in_rr);
      end
      @(posedge clk); #1;
      if (done) ndone++;
    end
    in_valid = 1'b0; ld_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_checks++; if (acc_c.size() != 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d exp 2", acc_c.size()); end
    if (acc_c.size() == 2) begin
      n_checks++; if (acc_c[1] - acc_c[0] != 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d exp 4", acc_c[1] - acc_c[0]); end
    end
    n_checks++; if (ndone != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d exp 2", ndone); end
    foreach (acc_op[j]) ref_exec(acc_op[j], acc_rd[j], acc_rr[j]);
    snap();
    for (int i = 0; i < NREG; i++) begin
      n_checks++; if (snap_r[i] !== ref_r[i]) begin n_fail++; $display("FAIL b2b_reg%0d: got %h exp %h", i, snap_r[i], ref_r[i]); end
    end
    n_checks++; if ({flag_c, flag_n, flag_z} !== {ref_c, ref_n, ref_z}) begin n_fail++; $display("FAIL b2b_flags: got %b exp %b", {flag_c, flag_n, flag_z}, {ref_c, ref_n, ref_z}); end
  endtask

  task automatic test_reset_midflight();
    int lat, nd, ndone; logic ill, sci, rdy; logic [7:0] srd, srr, sop;
    do_load(4'd1, 8'h12); do_load(4'd2, 8'h34);
    in_opcode = 8'hC0; in_rd = 4'd1; in_rr = 4'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    ref_clear();
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done || illegal) ndone++;
    end
    n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL rst_no_done: got %0d exp 0", ndone); end
    n_checks++; if ({flag_c, flag_n, flag_z} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b exp 000", {flag_c, flag_n, flag_z}); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", in_ready); end
    snap();
    for (int i = 0; i < NREG; i++) begin
      n_checks++; if (snap_r[i] !== 8'h00) begin n_fail++; $display("FAIL rst_reg%0d: got %h exp 00", i, snap_r[i]); end
    end
    do_load(4'd1, 8'h02); do_load(4'd2, 8'h03);
    run_instr(8'hC0, 4'd1, 4'd2, lat, nd, ill, srd, srr, sop, sci, rdy);
    ref_exec(8'hC0, 4'd1, 4'd2);
    snap();
    n_checks++; if (lat != 3 || snap_r[1] !== ref_r[1]) begin n_fail++; $display("FAIL rst_reissue: got lat %0d R1 %h exp 3 %h", lat, snap_r[1], ref_r[1]); end
  endtask

  task automatic test_random();
    int lat, nd; logic ill, sci, rdy; logic [7:0] srd, srr, sop, op;
    logic [3:0] rd, rr;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_load(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      end else begin
        op = 8'($urandom_range(0, 255));
        rd = 4'($urandom_range(0, 15));
        rr = 4'($urandom_range(0, 15));
        run_instr(op, rd, rr, lat, nd, ill, srd, srr, sop, sci, rdy);
        n_checks++; if (lat != 3 || nd != 1) begin n_fail++; $display("FAIL rnd_done_%0d: got lat %0d count %0d exp 3/1", it, lat, nd); end
        n_checks++; if (ill !== (op_class(op) == 2)) begin n_fail++; $display("FAIL rnd_illegal_%0d: op %h got %b exp %b", it, op, ill, op_class(op) == 2); end
        n_checks++; if ({srd, srr, sop, sci} !== {ref_r[rd], ref_r[rr], op, ref_c}) begin n_fail++; $display("FAIL rnd_alu_in_%0d: got %h exp %h", it, {srd, srr, sop, sci}, {ref_r[rd], ref_r[rr], op, ref_c}); end
        ref_exec(op, rd, rr);
        n_checks++; if ({flag_c, flag_n, flag_z} !== {ref_c, ref_n, ref_z}) begin n_fail++; $display("FAIL rnd_flags_%0d: op %h got %b exp %b", it, op, {flag_c, flag_n, flag_z}, {ref_c, ref_n, ref_z}); end
        snap();
        for (int i = 0; i < NREG; i++) begin
          n_checks++; if (snap_r[i] !== ref_r[i]) begin n_fail++; $display("FAIL rnd_reg%0d_%0d: op %h got %h exp %h", i, it, op, snap_r[i], ref_r[i]); end
        end
      end
    end
  endtask

  initial begin
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    in_valid = 1'b0; in_opcode = '0; in_rd = '0; in_rr = '0; dbg_addr = '0;
    ref_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    test_reset();
    test_add();
    test_mult();
    test_carry();
    test_illegal();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
